div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with a valid/ready handshake on both sides.
// Signed operations divide the operand magnitudes and fix the signs on the last
// iteration. Word operations (XLEN=64 only) use bits [31:0] and sign-extend the results.
module div_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_signed,
  input  logic            in_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_quot,
  output logic [XLEN-1:0] out_rem,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(XLEN);
  localparam logic [CntW-1:0] CntWord = CntW'(32);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Iteration state: r_quo shifts the dividend magnitude out of its MSB while
  // quotient bits are shifted in at the LSB.
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [CntW-1:0] r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_word;
  logic [XLEN-1:0] r_out_quot;
  logic [XLEN-1:0] r_out_rem;

  logic            w_word;
  logic [XLEN-1:0] w_a_eff;
  logic [XLEN-1:0] w_b_eff;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_sx_a;
  logic [XLEN-1:0] w_dz_rem;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_q_res;
  logic [XLEN-1:0] w_r_res;
  logic            w_last;

  // Word mode only exists on a 64-bit datapath.
  assign w_word = (XLEN == 64) && in_word;
  assign w_sx_a = XLEN'(signed'(in_a[31:0]));

  // Decode effective operands, their signs, magnitudes and the two special cases.
  always_comb begin
    w_a_eff = in_a;
    w_b_eff = in_b;
    w_a_neg = in_signed && in_a[XLEN-1];
    w_b_neg = in_signed && in_b[XLEN-1];
    w_min   = {1'b1, {(XLEN-1){1'b0}}};
    if (w_word) begin
      w_a_eff = in_signed ? w_sx_a : XLEN'(in_a[31:0]);
      w_b_eff = in_signed ? XLEN'(signed'(in_b[31:0])) : XLEN'(in_b[31:0]);
      w_a_neg = in_signed && in_a[31];
      w_b_neg = in_signed && in_b[31];
      w_min   = XLEN'(signed'(32'h8000_0000));
    end
    w_a_mag    = w_a_neg ? -w_a_eff : w_a_eff;
    w_b_mag    = w_b_neg ? -w_b_eff : w_b_eff;
    // Remainder of a divide-by-zero is always sign-extended in word mode.
    w_dz_rem   = w_word ? w_sx_a : in_a;
    w_div_zero = (w_b_eff == '0);
    w_ovf      = in_signed && (w_a_eff == w_min) && (w_b_eff == '1);
  end

  // One restoring step plus the sign fix-up applied on the final step.
  always_comb begin
    w_trial  = {r_rem, r_quo[XLEN-1]};
    w_sub    = w_trial - {1'b0, r_div};
    w_ge     = ~w_sub[XLEN];
    w_rem_nx = w_ge ? w_sub[XLEN-1:0] : w_trial[XLEN-1:0];
    w_quo_nx = {r_quo[XLEN-2:0], w_ge};
    w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
    w_q_res  = r_word ? XLEN'(signed'(w_q_fix[31:0])) : w_q_fix;
    w_r_res  = r_word ? XLEN'(signed'(w_r_fix[31:0])) : w_r_fix;
    w_last   = (r_cnt == CntW'(1));
  end

  // Next-state logic; flush wins over accept, completion and consume.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (flush) begin
          w_state_next = StIdle;
        end else if (in_valid) begin
          w_state_next = (w_div_zero || w_ovf) ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (flush) begin
          w_state_next = StIdle;
        end else if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (flush || out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_word     <= 1'b0;
      r_out_quot <= '0;
      r_out_rem  <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_rem   <= '0;
            // Word dividends sit in the upper half so 32 shifts consume them.
            r_quo   <= w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
            r_div   <= w_b_mag;
            r_cnt   <= w_word ? CntWord : CntFull;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_word  <= w_word;
            if (w_div_zero) begin
              r_out_quot <= '1;
              r_out_rem  <= w_dz_rem;
              r_cnt      <= '0;
            end else if (w_ovf) begin
              r_out_quot <= w_a_eff;
              r_out_rem  <= '0;
              r_cnt      <= '0;
            end
          end
        end
        StBusy: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CntW'(1);
          if (w_last) begin
            r_out_quot <= w_q_res;
            r_out_rem  <= w_r_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign out_quot  = r_out_quot;
  assign out_rem   = r_out_rem;

endmodule
